// File: rtl/go_pkg.sv
// Shared types and helpers for the Go board controller: stone encoding,
// controller states and the row/column to cell index mapping.
package go_pkg;

  localparam int BOARD_N = 9;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BLACK = 2'b01,
    WHITE = 2'b10
  } stone_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_COMMIT,
    S_REJECT,
    S_OVER
  } ctrl_state_t;

  function automatic logic [6:0] cell_idx(input logic [3:0] r, input logic [3:0] c);
    return 7'({3'b000, r} * 7'(BOARD_N) + {3'b000, c});
  endfunction

endpackage

// File: rtl/go_board_ctrl_edge_detect.sv
// Rising-edge detector for one debounced button. The history register is loaded
// from the live input during reset so a button held through reset yields no edge.
module edge_detect (
  input  logic vclock_in,
  input  logic reset_in,
  input  logic level_in,
  output logic pulse_out
);

  logic level_prev_reg;
  logic pulse_reg;

  always_ff @(posedge vclock_in) begin
    if (reset_in) begin
      level_prev_reg <= level_in;
      pulse_reg      <= 1'b0;
    end else begin
      level_prev_reg <= level_in;
      pulse_reg      <= level_in & ~level_prev_reg;
    end
  end

  assign pulse_out = pulse_reg;

endmodule

// File: rtl/go_board_ctrl.sv
// Live 9x9 Go board owner: sequences cursor moves, placements and passes from
// button edges, and republishes the board to the renderer on each vsync fall.
module go_board_ctrl #(
  parameter int BOARD_N    = 9,
  parameter int MAX_STONES = 81
) (
  input  logic                           vclock_in,
  input  logic                           reset_in,
  input  logic                           btn_up_in,
  input  logic                           btn_down_in,
  input  logic                           btn_left_in,
  input  logic                           btn_right_in,
  input  logic                           btn_place_in,
  input  logic                           btn_pass_in,
  input  logic                           vsync_in,
  output logic [2*BOARD_N*BOARD_N-1:0]   board_out,
  output logic [3:0]                     cursor_row_out,
  output logic [3:0]                     cursor_col_out,
  output logic                           turn_out,
  output logic                           illegal_out,
  output logic                           game_over_out,
  output logic [6:0]                     black_count_out,
  output logic [6:0]                     white_count_out
);

  import go_pkg::*;

  localparam int CELLS = BOARD_N * BOARD_N;
  localparam logic [3:0] LAST_POS = 4'(BOARD_N - 1);
  localparam logic [3:0] HOME_POS = 4'(BOARD_N / 2);

  // Button order, highest priority first: place, pass, up, down, left, right
  localparam int B_RIGHT = 0;
  localparam int B_LEFT  = 1;
  localparam int B_DOWN  = 2;
  localparam int B_UP    = 3;
  localparam int B_PASS  = 4;
  localparam int B_PLACE = 5;

  logic [5:0] btn_level;
  logic [5:0] btn_pulse;

  assign btn_level = {btn_place_in, btn_pass_in, btn_up_in, btn_down_in, btn_left_in, btn_right_in};

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_edge
      edge_detect u_edge (
        .vclock_in (vclock_in),
        .reset_in  (reset_in),
        .level_in  (btn_level[gi]),
        .pulse_out (btn_pulse[gi])
      );
    end
  endgenerate

  ctrl_state_t state_reg, state_next;
  logic [3:0]  cursor_row_reg, cursor_row_next;
  logic [3:0]  cursor_col_reg, cursor_col_next;
  logic        turn_reg, turn_next;
  logic [1:0]  pass_cnt_reg, pass_cnt_next;
  logic [6:0]  black_count_reg, black_count_next;
  logic [6:0]  white_count_reg, white_count_next;
  logic        vsync_prev_reg;
  logic        commit_en;
  logic [6:0]  cur_idx;
  logic [7:0]  stone_total;
  logic        vsync_fall;

  stone_t                board_reg [CELLS];
  logic [2*CELLS-1:0]    board_flat;

  assign cur_idx    = cell_idx(cursor_row_reg, cursor_col_reg);
  assign vsync_fall = vsync_prev_reg & ~vsync_in;

  always_comb begin
    state_next       = state_reg;
    cursor_row_next  = cursor_row_reg;
    cursor_col_next  = cursor_col_reg;
    turn_next        = turn_reg;
    pass_cnt_next    = pass_cnt_reg;
    black_count_next = black_count_reg;
    white_count_next = white_count_reg;
    commit_en        = 1'b0;
    illegal_out      = 1'b0;
    game_over_out    = 1'b0;
    stone_total      = {1'b0, black_count_reg} + {1'b0, white_count_reg};

    case (state_reg)
      S_IDLE: begin
        if (btn_pulse[B_PLACE]) begin
          state_next = S_CHECK;
        end else if (btn_pulse[B_PASS]) begin
          turn_next     = ~turn_reg;
          pass_cnt_next = pass_cnt_reg + 2'd1;
          if (pass_cnt_reg == 2'd1) state_next = S_OVER;
        end else if (btn_pulse[B_UP]) begin
          cursor_row_next = (cursor_row_reg == 4'd0) ? LAST_POS : cursor_row_reg - 4'd1;
        end else if (btn_pulse[B_DOWN]) begin
          cursor_row_next = (cursor_row_reg == LAST_POS) ? 4'd0 : cursor_row_reg + 4'd1;
        end else if (btn_pulse[B_LEFT]) begin
          cursor_col_next = (cursor_col_reg == 4'd0) ? LAST_POS : cursor_col_reg - 4'd1;
        end else if (btn_pulse[B_RIGHT]) begin
          cursor_col_next = (cursor_col_reg == LAST_POS) ? 4'd0 : cursor_col_reg + 4'd1;
        end
      end
      S_CHECK: begin
        state_next = (board_reg[cur_idx] == EMPTY) ? S_COMMIT : S_REJECT;
      end
      S_COMMIT: begin
        commit_en     = 1'b1;
        turn_next     = ~turn_reg;
        pass_cnt_next = 2'd0;
        if (turn_reg) white_count_next = white_count_reg + 7'd1;
        else          black_count_next = black_count_reg + 7'd1;
        // The filled-board test uses the counts as they will be after this commit
        stone_total = {1'b0, black_count_next} + {1'b0, white_count_next};
        state_next  = (stone_total == 8'(MAX_STONES)) ? S_OVER : S_IDLE;
      end
      S_REJECT: begin
        illegal_out = 1'b1;
        state_next  = S_IDLE;
      end
      S_OVER: begin
        game_over_out = 1'b1;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge vclock_in) begin
    if (reset_in) begin
      state_reg       <= S_IDLE;
      cursor_row_reg  <= HOME_POS;
      cursor_col_reg  <= HOME_POS;
      turn_reg        <= 1'b0;
      pass_cnt_reg    <= 2'd0;
      black_count_reg <= 7'd0;
      white_count_reg <= 7'd0;
      vsync_prev_reg  <= vsync_in;
      board_out       <= '0;
    end else begin
      state_reg       <= state_next;
      cursor_row_reg  <= cursor_row_next;
      cursor_col_reg  <= cursor_col_next;
      turn_reg        <= turn_next;
      pass_cnt_reg    <= pass_cnt_next;
      black_count_reg <= black_count_next;
      white_count_reg <= white_count_next;
      vsync_prev_reg  <= vsync_in;
      // Snapshot is of the board before any commit landing on this same edge
      if (vsync_fall) board_out <= board_flat;
    end
  end

  generate
    for (gi = 0; gi < CELLS; gi++) begin : g_cell
      always_ff @(posedge vclock_in) begin
        if (reset_in) begin
          board_reg[gi] <= EMPTY;
        end else if (commit_en && (cur_idx == 7'(gi))) begin
          board_reg[gi] <= turn_reg ? WHITE : BLACK;
        end
      end
      assign board_flat[gi*2 +: 2] = board_reg[gi];
    end
  endgenerate

  assign cursor_row_out  = cursor_row_reg;
  assign cursor_col_out  = cursor_col_reg;
  assign turn_out        = turn_reg;
  assign black_count_out = black_count_reg;
  assign white_count_out = white_count_reg;

endmodule

// File: tb/tb_go_board_ctrl.sv
// Bench for go_board_ctrl: a game-rule model advanced per button press with the
// documented latencies, compared against every output on every cycle.
module tb_go_board_ctrl;

  logic         clk_65mhz = 1'b0;
  logic         reset_drv = 1'b0;
  logic         btn_up, btn_down, btn_left, btn_right, btn_place, btn_pass;
  logic         vsync_drv = 1'b1;
  logic [161:0] board_out;
  logic [3:0]   cursor_row_out, cursor_col_out;
  logic         turn_out, illegal_out, game_over_out;
  logic [6:0]   black_count_out, white_count_out;

  localparam logic [5:0] B_PLACE = 6'b100000;
  localparam logic [5:0] B_PASS  = 6'b010000;
  localparam logic [5:0] B_UP    = 6'b001000;
  localparam logic [5:0] B_DOWN  = 6'b000100;
  localparam logic [5:0] B_LEFT  = 6'b000010;
  localparam logic [5:0] B_RIGHT = 6'b000001;

  go_board_ctrl #(.BOARD_N(9), .MAX_STONES(81)) dut (
    .vclock_in       (clk_65mhz),
    .reset_in        (reset_drv),
    .btn_up_in       (btn_up),
    .btn_down_in     (btn_down),
    .btn_left_in     (btn_left),
    .btn_right_in    (btn_right),
    .btn_place_in    (btn_place),
    .btn_pass_in     (btn_pass),
    .vsync_in        (vsync_drv),
    .board_out       (board_out),
    .cursor_row_out  (cursor_row_out),
    .cursor_col_out  (cursor_col_out),
    .turn_out        (turn_out),
    .illegal_out     (illegal_out),
    .game_over_out   (game_over_out),
    .black_count_out (black_count_out),
    .white_count_out (white_count_out)
  );

  always #7 clk_65mhz = ~clk_65mhz;

  // Game model
  int           m_board [81];
  int           m_row, m_col, m_black, m_white, m_passes;
  logic         m_turn, m_over, m_illegal;
  logic [161:0] m_bout;
  logic         m_vprev = 1'b1;
  logic         m_fell;
  logic         chk_en = 1'b0;
  int           tests = 0;
  int           fails = 0;
  int           illegal_seen = 0;

  task automatic check(input string name, input logic [161:0] act, input logic [161:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [161:0] model_flat();
    logic [161:0] f;
    f = '0;
    for (int i = 0; i < 81; i++) f[i*2 +: 2] = 2'(m_board[i]);
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 81; i++) m_board[i] = 0;
    m_row = 4; m_col = 4; m_turn = 1'b0; m_black = 0; m_white = 0;
    m_passes = 0; m_over = 1'b0; m_illegal = 1'b0; m_bout = '0;
    chk_en = 1'b1;
  endtask

  task automatic drive(input logic [5:0] m);
    {btn_place, btn_pass, btn_up, btn_down, btn_left, btn_right} = m;
  endtask

  // One clock edge; vsync falling edge publishes the pre-edge live board
  task automatic tick();
    logic         fall;
    logic [161:0] snap;
    fall = m_vprev & ~vsync_drv;
    snap = model_flat();
    @(posedge clk_65mhz);
    #1;
    m_vprev = vsync_drv;
    if (reset_drv) model_reset();
    else if (fall) begin
      m_bout = snap;
      m_fell = 1'b1;
    end
    if ($urandom_range(0, 3) == 0) vsync_drv = ~vsync_drv;
  endtask

  task automatic press(input logic [5:0] mask, input logic [5:0] late);
    int   idx;
    logic occ;
    drive(mask);
    tick();
    if (late != 6'd0) drive(mask | late);
    if (m_over || mask == 6'd0) begin
      tick(); tick();
    end else if (mask[5]) begin
      idx = m_row * 9 + m_col;
      occ = (m_board[idx] != 0);
      tick(); tick();
      if (occ) m_illegal = 1'b1;
      tick();
      m_illegal = 1'b0;
      if (!occ) begin
        m_board[idx] = m_turn ? 2 : 1;
        if (m_turn) m_white++; else m_black++;
        m_turn = ~m_turn;
        m_passes = 0;
        if (m_black + m_white == 81) m_over = 1'b1;
      end
    end else if (mask[4]) begin
      tick();
      m_turn = ~m_turn;
      m_passes++;
      if (m_passes >= 2) m_over = 1'b1;
    end else begin
      tick();
      if (mask[3])      m_row = (m_row == 0) ? 8 : m_row - 1;
      else if (mask[2]) m_row = (m_row == 8) ? 0 : m_row + 1;
      else if (mask[1]) m_col = (m_col == 0) ? 8 : m_col - 1;
      else              m_col = (m_col == 8) ? 0 : m_col + 1;
    end
    drive(6'd0);
    tick(); tick();
  endtask

  task automatic do_reset(input logic [5:0] held);
    drive(held);
    reset_drv = 1'b1;
    tick(); tick();
    reset_drv = 1'b0;
    tick();
    drive(6'd0);
    tick(); tick();
  endtask

  always @(negedge clk_65mhz) begin
    if (chk_en) begin
      check("cursor_row", 162'(cursor_row_out), 162'(m_row));
      check("cursor_col", 162'(cursor_col_out), 162'(m_col));
      check("turn", 162'(turn_out), 162'(m_turn));
      check("illegal", 162'(illegal_out), 162'(m_illegal));
      check("game_over", 162'(game_over_out), 162'(m_over));
      check("black_count", 162'(black_count_out), 162'(m_black));
      check("white_count", 162'(white_count_out), 162'(m_white));
      check("board_out", board_out, m_bout);
      if (illegal_out === 1'b1) illegal_seen++;
    end
  end

  initial begin
    int left_exp [5];
    int seen0;
    int r;
    logic [5:0] held;
    left_exp = '{3, 2, 1, 0, 8};
    drive(6'd0);
    tick();

    // Reset values
    do_reset(6'd0);
    check("rst_row", 162'(cursor_row_out), 162'd4);
    check("rst_col", 162'(cursor_col_out), 162'd4);
    check("rst_turn", 162'(turn_out), 162'd0);
    check("rst_board", board_out, 162'd0);
    check("rst_over", 162'(game_over_out), 162'd0);

    // Left wraps 0 -> 8
    for (int i = 0; i < 5; i++) begin
      press(B_LEFT, 6'd0);
      check("left_col", 162'(cursor_col_out), 162'(left_exp[i]));
      check("left_row", 162'(cursor_row_out), 162'd4);
    end
    for (int i = 0; i < 5; i++) press(B_RIGHT, 6'd0);

    // Legal place at (4,4), then wait for it to be published
    press(B_PLACE, 6'd0);
    check("place_black", 162'(black_count_out), 162'd1);
    check("place_turn", 162'(turn_out), 162'd1);
    m_fell = 1'b0;
    for (int i = 0; i < 60 && !m_fell; i++) tick();
    check("vsync_seen", 162'(m_fell), 162'd1);
    tick();
    check("pub_cell40", 162'(board_out[81:80]), 162'd1);

    // Occupied cell
    seen0 = illegal_seen;
    press(B_PLACE, 6'd0);
    check("illegal_pulses", 162'(illegal_seen - seen0), 162'd1);
    check("illegal_turn", 162'(turn_out), 162'd1);
    check("illegal_black", 162'(black_count_out), 162'd1);

    // Two passes end the game; later place ignored
    press(B_PASS, 6'd0);
    press(B_PASS, 6'd0);
    check("pass_over", 162'(game_over_out), 162'd1);
    press(B_LEFT, 6'd0);
    press(B_PLACE, 6'd0);
    check("over_black", 162'(black_count_out), 162'd1);
    check("over_white", 162'(white_count_out), 162'd0);

    // Placement clears the pass run
    do_reset(6'd0);
    press(B_PASS, 6'd0);
    press(B_PLACE, 6'd0);
    press(B_PASS, 6'd0);
    check("pass_reset_over", 162'(game_over_out), 162'd0);
    check("pass_reset_white", 162'(white_count_out), 162'd1);

    // Same-cycle place+up+right: only the place acts
    do_reset(6'd0);
    press(B_PLACE | B_UP | B_RIGHT, 6'd0);
    check("prio_row", 162'(cursor_row_out), 162'd4);
    check("prio_col", 162'(cursor_col_out), 162'd4);
    check("prio_black", 162'(black_count_out), 162'd1);

    // Edge arriving during S_CHECK is dropped
    press(B_RIGHT, 6'd0);
    press(B_PLACE, B_UP);
    check("drop_row", 162'(cursor_row_out), 162'd4);
    check("drop_white", 162'(white_count_out), 162'd1);

    // Place held through reset release
    do_reset(B_PLACE);
    check("held_black", 162'(black_count_out), 162'd0);

    // Reset in the middle of a placement
    drive(B_PLACE);
    tick();
    reset_drv = 1'b1;
    tick();
    reset_drv = 1'b0;
    drive(6'd0);
    for (int i = 0; i < 5; i++) tick();
    check("midrst_black", 162'(black_count_out), 162'd0);
    check("midrst_turn", 162'(turn_out), 162'd0);

    // Fill all 81 cells
    do_reset(6'd0);
    for (int k = 0; k < 81; k++) begin
      press(B_PLACE, 6'd0);
      press(B_RIGHT, 6'd0);
      if (k % 9 == 8) press(B_DOWN, 6'd0);
    end
    check("full_black", 162'(black_count_out), 162'd41);
    check("full_white", 162'(white_count_out), 162'd40);
    check("full_over", 162'(game_over_out), 162'd1);

    // Randomized play
    do_reset(6'd0);
    for (int n = 0; n < 400; n++) begin
      if (m_over && $urandom_range(0, 3) == 0) do_reset(6'd0);
      else if ($urandom_range(0, 59) == 0) begin
        held = 6'($urandom_range(0, 63));
        do_reset(held);
      end
      r = $urandom_range(0, 19);
      if (r < 4)       press(B_PLACE, 6'd0);
      else if (r < 6)  press(B_PASS, 6'd0);
      else if (r < 18) press(6'b000001 << $urandom_range(0, 3), 6'd0);
      else             press(6'($urandom_range(1, 63)), 6'd0);
    end

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/go_board_ctrl.md
# go_board_ctrl

Owns the live 9x9 Go board state and sequences edits to it from the user buttons. Tracks the cursor, whose turn it is, consecutive passes and stone counts. Publishes a frame-stable copy of the board to the `go_game` renderer. Sits between the `debounce` instances and `go_game` in `display`, on the 65 MHz pixel clock.

## Interface
Parameters:
- `BOARD_N`, 9: board dimension (rows = cols).
- `MAX_STONES`, 81: cell count; reaching it ends the game.

Ports:
- `vclock_in` in 1: 65 MHz clock; the only clock.
- `reset_in` in 1: reset, synchronous, active-high.
- `btn_up_in`, `btn_down_in`, `btn_left_in`, `btn_right_in` in 1 each: debounced level inputs.
- `btn_place_in` in 1: debounced level; place a stone at the cursor.
- `btn_pass_in` in 1: debounced level; pass the turn.
- `vsync_in` in 1: XVGA vsync, active low.
- `board_out` out 162: frame-stable board. Cell (r,c) is at bits [(r*9+c)*2 +: 2]. Encoding: 00 empty, 01 black, 10 white.
- `cursor_row_out`, `cursor_col_out` out 4 each: cursor position, 0..8.
- `turn_out` out 1: 0 = black to move, 1 = white to move.
- `illegal_out` out 1: one-cycle pulse when a placement is rejected.
- `game_over_out` out 1: sticky until reset.
- `black_count_out`, `white_count_out` out 7 each: stones on the board.

## Operation
- Every button goes through a rising-edge detector. Only edges act; held buttons do nothing further.
- FSM states: `S_IDLE`, `S_CHECK`, `S_COMMIT`, `S_REJECT`, `S_OVER`.
- In `S_IDLE`, a single edge is accepted per cycle. Priority: place > pass > up > down > left > right. Lower-priority edges in the same cycle are dropped.
- Cursor moves:
  - up decrements the row, down increments it, left decrements the column, right increments it.
  - Each wraps modulo 9: 0-1 gives 8, 8+1 gives 0.
  - A move updates the cursor only; the state stays `S_IDLE`.
- Place:
  - `S_IDLE` goes to `S_CHECK`, which reads the live cell at the cursor.
  - If the cell is empty, go to `S_COMMIT`:
    - write the cell with `turn_out ? 10 : 01`;
    - increment the matching count;
    - toggle `turn_out`;
    - clear the pass counter;
    - return to `S_IDLE`.
  - If the cell is occupied, go to `S_REJECT`: pulse `illegal_out`, leave turn and board unchanged, return to `S_IDLE`.
- Pass (`S_IDLE` only): toggle `turn_out` and increment the 2-bit pass counter. At 2 consecutive passes, go to `S_OVER`.
- After `S_COMMIT`, if `black_count + white_count == MAX_STONES`, go to `S_OVER` instead of `S_IDLE`.
- `S_OVER`:
  - `game_over_out` = 1;
  - all button edges are ignored;
  - the board publish keeps running;
  - exit only by reset.
- Edges arriving during `S_CHECK`, `S_COMMIT` or `S_REJECT` are dropped, not queued.
- Board publish: on a vsync falling edge (`vsync_in` 1 in the previous cycle, 0 now), copy the live board to `board_out`. No other event changes `board_out`. A commit in the same cycle as the vsync edge appears at the next frame.
- Captures and liberties are out of scope. The board only grows.

## Timing
- Reset values:
  - live board and `board_out` all zero;
  - cursor (4,4);
  - `turn_out` 0;
  - `illegal_out` 0;
  - `game_over_out` 0;
  - counts 0;
  - pass counter 0;
  - state `S_IDLE`;
  - edge-detector history registers loaded with the current inputs, so a button held through reset produces no edge.
- Cycle numbering: button rises at cycle N (sampled high at N, low at N-1); the edge pulse is registered at N+1.
- Move latency: cursor outputs change at N+2.
- Place latency:
  - `S_CHECK` during N+2;
  - `S_COMMIT` or `S_REJECT` during N+3;
  - live board, counts and turn updated at N+4;
  - `illegal_out` high exactly during N+3.
- Pass latency: `turn_out` toggles at N+2.
- `game_over_out` rises on the same cycle the FSM enters `S_OVER`.
- Reset mid-sequence (any state) returns everything to reset values on the next edge; a partial commit is lost.

## Structure
- Package `go_pkg` holds:
  - `typedef enum logic [1:0] {EMPTY=2'b00, BLACK=2'b01, WHITE=2'b10} stone_t`;
  - `BOARD_N`;
  - the FSM state enum `ctrl_state_t`;
  - the index function `cell_idx(r,c) = r*BOARD_N+c`.
- Sub-module `edge_detect` (`vclock_in`, `reset_in`, `level_in`, `pulse_out`): one instance per button, 6 total.
- The live board is an 81-entry `stone_t` register array, not BRAM. `go_game` requires parallel access to every cell.

## Test plan
- Reset, then 5 left edges → `cursor_col_out` 4→3→2→1→0→8; row stays 4.
- Place at (4,4) → at N+4, cell 40 = 01, `black_count_out` 1, `turn_out` 1. `board_out` is unchanged until the next vsync falling edge, then bits [81:80] = 01.
- Place again at (4,4) → `illegal_out` high for 1 cycle at N+3; `turn_out` and counts unchanged.
- Pass, pass → `game_over_out` = 1. A subsequent place edge leaves the board and counts unchanged.
- Pass, place (legal), pass → no game over; pass counter reset by the placement.
- Place, up and right asserted on the same rising cycle → only the placement happens; cursor unchanged. Holding place through reset release → no placement.
